aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Word-serial AES key expansion (FIPS-197) for AES-128/192/256, selected at runtime.
//  Expands one 32-bit word per clock into an internal word store.
//  Serves any round key on a random-access read port as soon as its four words exist.
//  Sits between the key register and the cipher round datapath; replaces the fixed 128-bit scheduler.
// PARAMETERS
//  MAX_NK      8  largest supported Nk (4, 6 or 8); sizes key_i and the store (4*(MAX_NR+1) words)
//  RK_OUT_REG  0  0: rk_o/rk_valid_o combinational from rk_idx_i; 1: registered, +1 cycle
// PORTS
//  clk_i       in   1          clock, all state on rising edge
//  rst_ni      in   1          asynchronous active-low reset
//  start_i     in   1          begin expansion of key_i (restarts if busy)
//  key_len_i   in   2          0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with start_i
//  key_i       in   32*MAX_NK  cipher key, word 0 at MSBs; shorter keys left-aligned, low bits ignored
//  busy_o      out  1          expansion in progress
//  done_o      out  1          all words of current schedule valid (level, until next start)
//  err_o       out  1          one-cycle pulse: start_i with illegal/unsupported key_len_i
//  nr_o        out  4          round count of latched mode (10/12/14), 0 before first start
//  rk_idx_i    in   4          round key index 0..nr_o
//  rk_o        out  128        round key rk_idx_i = {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//  rk_valid_o  out  1          rk_o holds a fully generated key for rk_idx_i
// BEHAVIOUR
//  Reset: busy_o=0, done_o=0, err_o=0, nr_o=0, rk_valid_o=0, rk_o=0, FSM=IDLE, word count wcnt=0.
//  Word store is not reset; rk_o is forced to 0 whenever rk_valid_o=0.
//  FSM IDLE -> EXPAND on legal start_i; EXPAND -> DONE when word Nw-1 written; DONE -> EXPAND on start_i.
//  Nk/Nr/Nw = 4/10/44, 6/12/52, 8/14/60. Key lengths with Nk>MAX_NK are illegal.
//  Start edge: latch mode, write w[0..Nk-1] from key_i in one cycle; wcnt=Nk, j=0, rcon=0x01; busy_o=1.
//  Each EXPAND cycle writes w[wcnt]:
//   t = w[wcnt-1]
//   j==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}; rcon <= xtime(rcon) (0x80 -> 0x1b)
//   Nk==8 and j==4: t = SubWord(t)
//   w[wcnt] = w[wcnt-Nk] ^ t
//   Then wcnt++ and j = (j==Nk-1) ? 0 : j+1. Counter only, no division.
//  Last write: busy_o falls and done_o rises on the same edge.
//   Start edge to done_o is Nw-Nk cycles: 40/46/52.
//  rk_valid_o = (rk_idx_i <= nr_o) && (wcnt >= 4*rk_idx_i+4). Round 0 is valid the cycle after start.
//   Later round keys become valid while busy; the cipher may consume them early.
//  rk_idx_i > nr_o: rk_valid_o=0, rk_o=0.
//  RK_OUT_REG=1: both outputs lag rk_idx_i/wcnt by exactly one cycle.
//  start_i while busy: abort. Restart as from IDLE with the new key on that edge; done_o stays 0.
//   Previously generated words count as invalid (wcnt reset).
//  Illegal start_i: err_o pulses, state and all other outputs unchanged (DONE schedule remains readable).
//  rst_ni low mid-expansion: immediate return to reset values; no partial key is reported valid.
//  One SubWord instance (4 S-boxes) serves both substitution cases; the store has one write port per cycle.
// STRUCTURE
//  aes_pkg (shared): sbox table, xtime() function, key_len_e enum, nk_of()/nr_of() lookup functions.
//  Sub-module aes_sub_word: 32-bit SubWord, 4 parallel S-box lookups from aes_pkg; reused by the cipher datapath.
//  Top: FSM, wcnt/j/rcon counters, word store, read mux, optional output register.
// TESTING
//  AES-128, key 2b7e151628aed2a6abf7158809cf4f3c
//   -> done_o exactly 40 cycles after start; rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//   -> done after 46 cycles; nr_o=12; rk[12] = e98ba06f448c773c8ecc720401002202.
//  AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//   -> done after 52 cycles; rk[14] = fe4890d1e6188d0b046df344706c631e.
//  Early read: sweep rk_idx_i during AES-128 expansion
//   -> rk_valid_o for r rises exactly 4r cycles after start (r>=1), r=0 after 1; rk_idx_i=11 never valid.
//  Abort and error: restart with a new 256-bit key at cycle 20 of AES-128
//   -> FIPS rk[14] after 52 more cycles, no stale valid.
//  key_len_i=3 start -> err_o one-cycle pulse, prior schedule intact.
//  Reset: drop rst_ni at cycle 10 -> all outputs 0 asynchronously; fresh start matches reference vectors.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared definitions: S-box table, GF(2^8) helper and key length lookups.
// Used by the key schedule and the cipher round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_ILL = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  // Entry 0x00 sits in the top byte of the table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = {~b, 3'b000};
    return SBOX_TBL[pos +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Control and round-key read bundle of the AES key schedule.
// master drives start/key/index, slave returns status and round keys.
interface aes_key_schedule_if #(
  parameter int MAX_NK = 8
);
  logic                  start_i;
  logic [1:0]            key_len_i;
  logic [32*MAX_NK-1:0]  key_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [3:0]            nr_o;
  logic [3:0]            rk_idx_i;
  logic [127:0]          rk_o;
  logic                  rk_valid_o;

  modport master (
    output start_i, key_len_i, key_i, rk_idx_i,
    input  busy_o, done_o, err_o, nr_o, rk_o, rk_valid_o
  );

  modport slave (
    input  start_i, key_len_i, key_i, rk_idx_i,
    output busy_o, done_o, err_o, nr_o, rk_o, rk_valid_o
  );
endinterface

// File: rtl/aes_sub_word.sv
// 32-bit AES SubWord: four parallel S-box lookups.
// Shared between the key schedule and the round datapath.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  import aes_pkg::*;

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end
  end
endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expansion, one word per clock,
// with a random-access round key read port.
module aes_key_schedule #(
  parameter int MAX_NK     = 8,
  parameter bit RK_OUT_REG = 1'b0
) (
  input logic               clk_i,
  input logic               rst_ni,
  aes_key_schedule_if.slave ks
);
  import aes_pkg::*;

  localparam int NW_MAX = 4 * (MAX_NK + 7);

  ks_state_e   state_q, state_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic        err_q, err_d;
  logic [31:0] w_q [NW_MAX];

  key_len_e    len;
  logic [3:0]  nk_new;
  logic        start_ok;
  logic        load;
  logic        wr_en;
  logic [5:0]  nw;
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] tmp;
  logic [31:0] wr_data;

  assign len      = key_len_e'(ks.key_len_i);
  assign nk_new   = nk_of(len);
  assign start_ok = ks.start_i && (nk_new != 4'd0)
                    && (int'(nk_new) <= MAX_NK);
  assign nw       = {nr_q, 2'b00} + 6'd4;

  assign prev   = w_q[wcnt_q - 6'd1];
  assign back   = w_q[wcnt_q - {2'b00, nk_q}];
  assign sub_in = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    tmp = prev;
    unique case (1'b1)
      (j_q == 3'd0):                  tmp = sub_out ^ {rcon_q, 24'h0};
      (nk_q == 4'd8 && j_q == 3'd4):  tmp = sub_out;
      default:                        tmp = prev;
    endcase
  end

  assign wr_data = back ^ tmp;

  // A legal start always wins, so a restart aborts a running expansion.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    err_d   = ks.start_i && !start_ok;
    load    = 1'b0;
    wr_en   = 1'b0;
    if (start_ok) begin
      load    = 1'b1;
      state_d = ST_EXPAND;
      nk_d    = nk_new;
      nr_d    = nr_of(len);
      wcnt_d  = {2'b00, nk_new};
      j_d     = 3'd0;
      rcon_d  = 8'h01;
    end else if (state_q == ST_EXPAND) begin
      wr_en  = 1'b1;
      wcnt_d = wcnt_q + 6'd1;
      j_d    = (j_q == nk_q[2:0] - 3'd1) ? 3'd0 : j_q + 3'd1;
      if (j_q == 3'd0) rcon_d = xtime(rcon_q);
      if (wcnt_q == nw - 6'd1) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      j_q     <= '0;
      rcon_q  <= 8'h01;
      nk_q    <= '0;
      nr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      j_q     <= j_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
    end
  end

  // Words past Nk of a short key are refilled before wcnt covers them.
  always_ff @(posedge clk_i) begin
    if (load) begin
      for (int i = 0; i < MAX_NK; i++) begin
        w_q[i] <= ks.key_i[32*(MAX_NK-1-i) +: 32];
      end
    end else if (wr_en) begin
      w_q[wcnt_q] <= wr_data;
    end
  end

  logic [6:0]   need;
  logic         rd_valid;
  logic [5:0]   base;
  logic [127:0] rd_key;

  always_comb begin
    need     = {1'b0, ks.rk_idx_i, 2'b00} + 7'd4;
    rd_valid = (ks.rk_idx_i <= nr_q) && ({1'b0, wcnt_q} >= need);
    base     = rd_valid ? {ks.rk_idx_i, 2'b00} : 6'd0;
    rd_key   = '0;
    if (rd_valid) begin
      rd_key = {w_q[base], w_q[base + 6'd1],
                w_q[base + 6'd2], w_q[base + 6'd3]};
    end
  end

  if (RK_OUT_REG) begin : g_rk_reg
    logic         rk_valid_q;
    logic [127:0] rk_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rk_valid_q <= 1'b0;
        rk_q       <= '0;
      end else begin
        rk_valid_q <= rd_valid;
        rk_q       <= rd_key;
      end
    end
    assign ks.rk_valid_o = rk_valid_q;
    assign ks.rk_o       = rk_q;
  end else begin : g_rk_comb
    assign ks.rk_valid_o = rd_valid;
    assign ks.rk_o       = rd_key;
  end

  assign ks.busy_o = (state_q == ST_EXPAND);
  assign ks.done_o = (state_q == ST_DONE);
  assign ks.err_o  = err_q;
  assign ks.nr_o   = nr_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized scoreboard bench for aes_key_schedule: a FIPS-197 model
// with an S-box derived from GF(2^8) inversion, plus published answers.
module tb_aes_key_schedule;
  localparam int MAX_NK = 8;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  aes_key_schedule_if #(.MAX_NK(MAX_NK)) ks_if ();

  aes_key_schedule #(
    .MAX_NK     (MAX_NK),
    .RK_OUT_REG (1'b0)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ks     (ks_if)
  );

  typedef struct {
    int           cyc;
    string        tag;
    logic         busy;
    logic         done;
    logic [3:0]   nr;
    logic         valid;
    logic [127:0] rk;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] nr;
  } done_t;

  exp_t  rd_q [$];
  done_t done_q [$];
  int    err_q [$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok,
                     input logic [134:0] got, input logic [134:0] want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  bit          m_have = 1'b0;
  int          m_nk, m_nr, m_start;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
              ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int m = 1; m < k; m++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon(i/nk), 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic exp_t model_exp(input int k, input logic [3:0] r,
                                     input string tag);
    exp_t e;
    int   ri, nw, avail;
    ri      = int'(r);
    e.cyc   = k;
    e.tag   = tag;
    e.busy  = 1'b0;
    e.done  = 1'b0;
    e.nr    = 4'd0;
    e.valid = 1'b0;
    e.rk    = '0;
    if (m_have) begin
      nw    = 4 * (m_nr + 1);
      avail = m_nk + (k - m_start);
      if (avail >= nw) begin
        avail  = nw;
        e.done = 1'b1;
      end else begin
        e.busy = 1'b1;
      end
      e.nr    = 4'(m_nr);
      e.valid = (ri <= m_nr) && (4*ri + 4 <= avail);
      if (e.valid) e.rk = {mw[4*ri], mw[4*ri+1], mw[4*ri+2], mw[4*ri+3]};
    end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] r, input string tag);
    @(posedge clk_i);
    #1;
    ks_if.start_i  = 1'b0;
    ks_if.rk_idx_i = r;
    rd_q.push_back(model_exp(cyc, r, tag));
  endtask

  task automatic step_rand(input string tag);
    step(4'($urandom_range(0, 15)), tag);
  endtask

  task automatic issue_start(input logic [1:0] len, input logic [255:0] key,
                             input logic [3:0] r);
    int    nk;
    done_t d;
    @(posedge clk_i);
    #1;
    ks_if.start_i   = 1'b1;
    ks_if.key_len_i = len;
    ks_if.key_i     = key;
    ks_if.rk_idx_i  = r;
    rd_q.push_back(model_exp(cyc, r, "start"));
    if (len == 2'd3) begin
      err_q.push_back(cyc + 1);
    end else begin
      nk = 4 + 2 * int'(len);
      while (done_q.size() != 0 && done_q[$].cyc > cyc) void'(done_q.pop_back());
      expand(key, nk);
      m_have  = 1'b1;
      m_nk    = nk;
      m_nr    = nk + 6;
      m_start = cyc + 1;
      d.cyc   = m_start + 4 * (nk + 7) - nk;
      d.nr    = 4'(nk + 6);
      done_q.push_back(d);
    end
  endtask

  task automatic kat(input logic [3:0] r, input logic [3:0] nr,
                     input logic [127:0] rk, input string tag);
    exp_t e;
    @(posedge clk_i);
    #1;
    ks_if.start_i  = 1'b0;
    ks_if.rk_idx_i = r;
    e.cyc   = cyc;
    e.tag   = tag;
    e.busy  = 1'b0;
    e.done  = 1'b1;
    e.nr    = nr;
    e.valid = 1'b1;
    e.rk    = rk;
    rd_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #3;
    rst_ni        = 1'b0;
    ks_if.start_i = 1'b0;
    m_have        = 1'b0;
    while (done_q.size() != 0 && done_q[$].cyc >= cyc) void'(done_q.pop_back());
    rd_q.push_back(model_exp(cyc, ks_if.rk_idx_i, "rst_async"));
    repeat (2) step_rand("rst_hold");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rd_q.push_back(model_exp(cyc, ks_if.rk_idx_i, "rst_release"));
  endtask

  function automatic logic [255:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  exp_t         me;
  done_t        md;
  logic [134:0] got_v, want_v;
  logic         done_prev = 1'b0;
  int           e_cyc;

  always @(negedge clk_i) begin
    while (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      me     = rd_q.pop_front();
      got_v  = {ks_if.busy_o, ks_if.done_o, ks_if.nr_o,
                ks_if.rk_valid_o, ks_if.rk_o};
      want_v = {me.busy, me.done, me.nr, me.valid, me.rk};
      chk(me.tag, got_v === want_v, got_v, want_v);
    end
    if (ks_if.err_o !== 1'b0) begin
      if (err_q.size() == 0) begin
        chk("err_spurious", 1'b0, 135'(ks_if.err_o), 135'(0));
      end else begin
        e_cyc = err_q.pop_front();
        chk("err_pulse", e_cyc == cyc, 135'(cyc), 135'(e_cyc));
      end
    end
    while (err_q.size() != 0 && err_q[0] < cyc) begin
      e_cyc = err_q.pop_front();
      chk("err_missing", 1'b0, 135'(cyc), 135'(e_cyc));
    end
    if (ks_if.done_o === 1'b1 && done_prev !== 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_spurious", 1'b0, 135'(cyc), 135'(0));
      end else begin
        md = done_q.pop_front();
        chk("done_time", md.cyc == cyc && md.nr == ks_if.nr_o,
            {cyc, ks_if.nr_o}, {md.cyc, md.nr});
      end
    end
    while (done_q.size() != 0 && done_q[0].cyc < cyc) begin
      md = done_q.pop_front();
      chk("done_missing", 1'b0, 135'(cyc), 135'(md.cyc));
    end
    done_prev = ks_if.done_o;
  end

  // ---------------- sequence ----------------
  initial begin
    int r;
    ks_if.start_i   = 1'b0;
    ks_if.key_len_i = 2'd0;
    ks_if.key_i     = '0;
    ks_if.rk_idx_i  = 4'd0;
    build_sbox();

    repeat (3) step_rand("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (2) step_rand("idle");

    // AES-128 with a sweep hitting each round key on both sides of its rise
    issue_start(2'd0, {K128, 128'(rkey())}, 4'd0);
    for (int t = 0; t < 42; t++) begin
      if (t % 4 == 0)      r = t / 4;
      else if (t % 4 == 3) r = (t + 1) / 4;
      else                 r = $urandom_range(0, 12);
      step(4'(r), "sweep128");
    end
    kat(4'd10, 4'd10, RK128, "kat128");
    step(4'd11, "idx11");

    issue_start(2'd1, {K192, 64'(rkey())}, 4'd0);
    repeat (47) step_rand("run192");
    kat(4'd12, 4'd12, RK192, "kat192");

    issue_start(2'd3, rkey(), 4'd12);
    repeat (3) step_rand("after_err");
    kat(4'd12, 4'd12, RK192, "kat192_kept");

    issue_start(2'd2, K256, 4'd0);
    repeat (53) step_rand("run256");
    kat(4'd14, 4'd14, RK256, "kat256");

    issue_start(2'd0, rkey(), 4'd0);
    repeat (19) step_rand("pre_abort");
    issue_start(2'd2, K256, 4'd1);
    repeat (53) step_rand("post_abort");
    kat(4'd14, 4'd14, RK256, "kat_abort");

    issue_start(2'd1, rkey(), 4'd0);
    repeat (9) step_rand("pre_reset");
    do_reset();
    issue_start(2'd0, {K128, 128'(rkey())}, 4'd0);
    repeat (41) step_rand("post_reset");
    kat(4'd10, 4'd10, RK128, "kat128_reset");

    repeat (500) begin
      if ($urandom_range(0, 39) == 0)
        issue_start(2'($urandom_range(0, 3)), rkey(), 4'($urandom_range(0, 15)));
      else
        step_rand("random");
    end
    repeat (60) step_rand("drain");

    @(negedge clk_i);
    @(negedge clk_i);
    while (done_q.size() != 0) begin
      md = done_q.pop_front();
      chk("done_never", 1'b0, 135'(cyc), 135'(md.cyc));
    end
    while (err_q.size() != 0) begin
      e_cyc = err_q.pop_front();
      chk("err_never", 1'b0, 135'(cyc), 135'(e_cyc));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
